// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall sequencer: load-use bubbles, branch flush, mem freeze.
// Optional perf counters built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int REG_NUM_BITWIDTH = 5,
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int FLUSH_DEPTH      = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [REG_NUM_BITWIDTH-1:0] id_Rs1,
  input  logic [REG_NUM_BITWIDTH-1:0] id_Rs2,
  input  logic                        id_useRs1,
  input  logic                        id_useRs2,
  input  logic                        ex_memRead,
  input  logic [REG_NUM_BITWIDTH-1:0] ex_regToWrite,
  input  logic                        ex_branchTaken,
  input  logic                        mem_busy,
  input  logic                        perf_clr,
  output logic                        pc_write,
  output logic                        ifid_write,
  output logic                        ifid_flush,
  output logic                        doNOP,
  output logic                        pipe_hold,
  output logic [1:0]                  hz_state,
  output logic [15:0]                 stall_cycles,
  output logic [15:0]                 flush_cycles
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10
  } hz_state_e;

  hz_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  logic lu_hz;
  logic pc_w_c, ifid_w_c, flush_c, nop_c, hold_c;

  assign lu_hz = ex_memRead
    & (ex_regToWrite != '0)
    & ((id_useRs1 & (ex_regToWrite == id_Rs1))
     | (id_useRs2 & (ex_regToWrite == id_Rs2)));

  // Next-state and Mealy control outputs
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pc_w_c   = 1'b1;
    ifid_w_c = 1'b1;
    flush_c  = 1'b0;
    nop_c    = 1'b0;
    hold_c   = 1'b0;
    if (mem_busy) begin
      hold_c   = 1'b1;
      pc_w_c   = 1'b0;
      ifid_w_c = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (ex_branchTaken) begin
            flush_c = 1'b1;
            nop_c   = 1'b1;
            if (FLUSH_DEPTH > 1) begin
              state_d = FLUSH;
              cnt_d   = 3'(FLUSH_DEPTH - 1);
            end
          end else if (lu_hz) begin
            pc_w_c   = 1'b0;
            ifid_w_c = 1'b0;
            nop_c    = 1'b1;
            if (LOAD_USE_BUBBLES > 1) begin
              state_d = STALL;
              cnt_d   = 3'(LOAD_USE_BUBBLES - 1);
            end
          end
        end
        STALL: begin
          pc_w_c   = 1'b0;
          ifid_w_c = 1'b0;
          nop_c    = 1'b1;
          cnt_d    = cnt_q - 3'd1;
          if (cnt_q <= 3'd1) begin
            state_d = RUN;
            cnt_d   = 3'd0;
          end
        end
        FLUSH: begin
          flush_c = 1'b1;
          nop_c   = 1'b1;
          cnt_d   = cnt_q - 3'd1;
          if (cnt_q <= 3'd1) begin
            state_d = RUN;
            cnt_d   = 3'd0;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = 3'd0;
        end
      endcase
    end
  end

  // State and sequence counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset forces a bubble into IF/ID and ID/EX and blocks the PC
  assign pc_write   = rst_n & pc_w_c;
  assign ifid_write = rst_n & ifid_w_c;
  assign ifid_flush = ~rst_n | flush_c;
  assign doNOP      = ~rst_n | nop_c;
  assign pipe_hold  = rst_n & hold_c;
  assign hz_state   = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_q, stall_d;
  logic [15:0] flushc_q, flushc_d;

  // Saturating perf counters, clear wins over increment
  always_comb begin
    stall_d  = stall_q;
    flushc_d = flushc_q;
    if (perf_clr) begin
      stall_d  = '0;
      flushc_d = '0;
    end else if (!mem_busy) begin
      if (nop_c && !flush_c && stall_q != 16'hFFFF)
        stall_d = stall_q + 16'd1;
      if (flush_c && flushc_q != 16'hFFFF)
        flushc_d = flushc_q + 16'd1;
    end
  end

  // Perf counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q  <= '0;
      flushc_q <= '0;
    end else begin
      stall_q  <= stall_d;
      flushc_q <= flushc_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_cycles = flushc_q;
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr;
  assign stall_cycles    = '0;
  assign flush_cycles    = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two configs driven in lockstep,
// expected control vectors queued per cycle and popped at sample.
module tb_pipeline_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {pc_write, ifid_write, ifid_flush, doNOP, pipe_hold, hz_state}
  localparam logic [6:0] DEF  = 7'b1100000;
  localparam logic [6:0] RSTV = 7'b0011000;
  localparam logic [6:0] LU   = 7'b0001000;
  localparam logic [6:0] ST   = 7'b0001001;
  localparam logic [6:0] BR   = 7'b1111000;
  localparam logic [6:0] FL   = 7'b1111010;
  localparam logic [6:0] HD0  = 7'b0000100;
  localparam logic [6:0] HD1  = 7'b0000101;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] id_Rs1, id_Rs2, ex_regToWrite;
  logic id_useRs1, id_useRs2, ex_memRead;
  logic ex_branchTaken, mem_busy, perf_clr;

  logic pc_a, ifw_a, fl_a, nop_a, hold_a;
  logic pc_b, ifw_b, fl_b, nop_b, hold_b;
  logic [1:0] st_a, st_b;
  logic [15:0] sc_a, fc_a, sc_b, fc_b;

  int n_chk = 0;
  int n_fail = 0;
  logic [6:0] q_a[$];
  logic [6:0] q_b[$];
  logic [15:0] m_sa, m_fa, m_sb, m_fb;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .REG_NUM_BITWIDTH(5),
    .LOAD_USE_BUBBLES(1),
    .FLUSH_DEPTH(1)
  ) u_a (
    .clk(clk), .rst_n(rst_n),
    .id_Rs1(id_Rs1), .id_Rs2(id_Rs2),
    .id_useRs1(id_useRs1), .id_useRs2(id_useRs2),
    .ex_memRead(ex_memRead), .ex_regToWrite(ex_regToWrite),
    .ex_branchTaken(ex_branchTaken), .mem_busy(mem_busy),
    .perf_clr(perf_clr),
    .pc_write(pc_a), .ifid_write(ifw_a), .ifid_flush(fl_a),
    .doNOP(nop_a), .pipe_hold(hold_a), .hz_state(st_a),
    .stall_cycles(sc_a), .flush_cycles(fc_a)
  );

  pipeline_hazard_ctrl #(
    .REG_NUM_BITWIDTH(5),
    .LOAD_USE_BUBBLES(3),
    .FLUSH_DEPTH(2)
  ) u_b (
    .clk(clk), .rst_n(rst_n),
    .id_Rs1(id_Rs1), .id_Rs2(id_Rs2),
    .id_useRs1(id_useRs1), .id_useRs2(id_useRs2),
    .ex_memRead(ex_memRead), .ex_regToWrite(ex_regToWrite),
    .ex_branchTaken(ex_branchTaken), .mem_busy(mem_busy),
    .perf_clr(perf_clr),
    .pc_write(pc_b), .ifid_write(ifw_b), .ifid_flush(fl_b),
    .doNOP(nop_b), .pipe_hold(hold_b), .hz_state(st_b),
    .stall_cycles(sc_b), .flush_cycles(fc_b)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // 0 idle, 1 hazard on rs2, 2 load to x0, 3 hazard on rs1,
  // 4 load whose dest matches only an unused source
  task automatic set_regs(input int lu);
    ex_memRead = 1'b0; ex_regToWrite = 5'd0;
    id_Rs1 = 5'd0; id_Rs2 = 5'd0;
    id_useRs1 = 1'b0; id_useRs2 = 1'b0;
    case (lu)
      1: begin
        ex_memRead = 1'b1; ex_regToWrite = 5'd5;
        id_Rs1 = 5'd3; id_Rs2 = 5'd5;
        id_useRs1 = 1'b1; id_useRs2 = 1'b1;
      end
      2: begin
        ex_memRead = 1'b1; ex_regToWrite = 5'd0;
        id_useRs1 = 1'b1; id_useRs2 = 1'b1;
      end
      3: begin
        ex_memRead = 1'b1; ex_regToWrite = 5'd7;
        id_Rs1 = 5'd7; id_Rs2 = 5'd1;
        id_useRs1 = 1'b1;
      end
      4: begin
        ex_memRead = 1'b1; ex_regToWrite = 5'd6;
        id_Rs1 = 5'd6; id_Rs2 = 5'd2;
        id_useRs2 = 1'b1;
      end
      default: ;
    endcase
  endtask

  function automatic logic [15:0] sat_inc(input logic [15:0] v,
                                          input bit en);
    if (en && v != 16'hFFFF) return v + 16'd1;
    return v;
  endfunction

  task automatic step(input string tag, input bit rst, input int lu,
                      input bit br, input bit busy, input bit clr,
                      input logic [6:0] ea, input logic [6:0] eb);
    logic [6:0] xa, xb;
    @(negedge clk);
    rst_n = ~rst;
    set_regs(lu);
    ex_branchTaken = br;
    mem_busy = busy;
    perf_clr = clr;
    q_a.push_back(ea);
    q_b.push_back(eb);
    #2;
    if (q_a.size() == 0 || q_b.size() == 0) begin
      check({tag, "_q"}, 32'd0, 32'd1);
    end else begin
      xa = q_a.pop_front();
      xb = q_b.pop_front();
      check({tag, "_a"},
            {25'd0, pc_a, ifw_a, fl_a, nop_a, hold_a, st_a}, {25'd0, xa});
      check({tag, "_b"},
            {25'd0, pc_b, ifw_b, fl_b, nop_b, hold_b, st_b}, {25'd0, xb});
      if (rst) begin
        m_sa = '0; m_fa = '0; m_sb = '0; m_fb = '0;
      end else if (clr) begin
        m_sa = '0; m_fa = '0; m_sb = '0; m_fb = '0;
      end else begin
        m_sa = sat_inc(m_sa, xa[3] & ~xa[4]);
        m_fa = sat_inc(m_fa, xa[4]);
        m_sb = sat_inc(m_sb, xb[3] & ~xb[4]);
        m_fb = sat_inc(m_fb, xb[4]);
      end
    end
  endtask

  task automatic check_perf(input string tag);
    check({tag, "_sa"}, {16'd0, sc_a}, PERF ? {16'd0, m_sa} : 32'd0);
    check({tag, "_fa"}, {16'd0, fc_a}, PERF ? {16'd0, m_fa} : 32'd0);
    check({tag, "_sb"}, {16'd0, sc_b}, PERF ? {16'd0, m_sb} : 32'd0);
    check({tag, "_fb"}, {16'd0, fc_b}, PERF ? {16'd0, m_fb} : 32'd0);
  endtask

  initial begin
    m_sa = '0; m_fa = '0; m_sb = '0; m_fb = '0;
    set_regs(0);
    ex_branchTaken = 1'b0; mem_busy = 1'b0; perf_clr = 1'b0;

    step("rst",    1, 0, 0, 0, 0, RSTV, RSTV);
    check_perf("rst_cnt");
    step("idle0",  0, 0, 0, 0, 0, DEF,  DEF);
    step("lu",     0, 1, 0, 0, 0, LU,   LU);
    step("lu_s1",  0, 0, 0, 0, 0, DEF,  ST);
    step("lu_s2",  0, 0, 0, 0, 0, DEF,  ST);
    step("lu_end", 0, 0, 0, 0, 0, DEF,  DEF);
    step("x0",     0, 2, 0, 0, 0, DEF,  DEF);
    step("unused", 0, 4, 0, 0, 0, DEF,  DEF);
    step("br",     0, 0, 1, 0, 0, BR,   BR);
    step("br_f1",  0, 0, 0, 0, 0, DEF,  FL);
    step("br_end", 0, 0, 0, 0, 0, DEF,  DEF);
    step("brlu",   0, 3, 1, 0, 0, BR,   BR);
    step("brlu_f", 0, 0, 0, 0, 0, DEF,  FL);
    step("brlu_e", 0, 0, 0, 0, 0, DEF,  DEF);
    step("fz_lu",  0, 1, 0, 0, 0, LU,   LU);
    for (int i = 0; i < 4; i++)
      step("fz_hold", 0, 0, 0, 1, 0, HD0, HD1);
    step("fz_s1",  0, 0, 0, 0, 0, DEF,  ST);
    step("fz_s2",  0, 0, 0, 0, 0, DEF,  ST);
    step("fz_end", 0, 0, 0, 0, 0, DEF,  DEF);
    step("pb_hold", 0, 1, 1, 1, 0, HD0, HD0);
    step("pb_br",  0, 1, 1, 0, 0, BR,   BR);
    step("pb_f",   0, 0, 0, 0, 0, DEF,  FL);
    step("pb_end", 0, 0, 0, 0, 0, DEF,  DEF);
    check_perf("mid_cnt");

    step("rf_br",  0, 0, 1, 0, 0, BR,   BR);
    step("rf_rst", 1, 0, 0, 0, 0, RSTV, RSTV);
    check_perf("rf_cnt");
    step("rf_rel", 0, 0, 0, 0, 0, DEF,  DEF);

    step("pc_lu1", 0, 1, 0, 0, 0, LU,   LU);
    step("pc_i1",  0, 0, 0, 0, 0, DEF,  ST);
    step("pc_i2",  0, 0, 0, 0, 0, DEF,  ST);
    step("pc_i3",  0, 0, 0, 0, 0, DEF,  DEF);
    step("pc_lu2", 0, 3, 0, 0, 0, LU,   LU);
    step("pc_i4",  0, 0, 0, 0, 0, DEF,  ST);
    step("pc_i5",  0, 0, 0, 0, 0, DEF,  ST);
    step("pc_br",  0, 0, 1, 0, 0, BR,   BR);
    step("pc_i6",  0, 0, 0, 0, 0, DEF,  FL);
    step("pc_i7",  0, 0, 0, 0, 0, DEF,  DEF);
    check_perf("pc_cnt");
    check("pc_sa_val", {16'd0, sc_a}, PERF ? 32'd2 : 32'd0);
    check("pc_fa_val", {16'd0, fc_a}, PERF ? 32'd1 : 32'd0);
    step("pc_clr", 0, 0, 0, 0, 1, DEF,  DEF);
    step("pc_post", 0, 0, 0, 0, 0, DEF, DEF);
    check_perf("clr_cnt");

    @(negedge clk);
    perf_clr = 1'b0;
    set_regs(1);
    repeat (70000) @(negedge clk);
    set_regs(0);
    repeat (4) @(negedge clk);
    #2;
    check("sat_sa", {16'd0, sc_a}, PERF ? 32'h0000FFFF : 32'd0);
    check("sat_sb", {16'd0, sc_b}, PERF ? 32'h0000FFFF : 32'd0);
    check("sat_fa", {16'd0, fc_a}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
